// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired multi-cycle control unit driving data_path strobes
module control_sequencer #(
   parameter int NREG = 16,
   parameter int OPW  = 5
) (
   input  logic            Clock,
   input  logic            clear,
   input  logic            Run,
   input  logic [31:0]     IR,
   output logic            PCout,
   output logic            MDRout,
   output logic            Zhighout,
   output logic            Zlowout,
   output logic            MARin,
   output logic            PCin,
   output logic            MDRin,
   output logic            IRin,
   output logic            Yin,
   output logic            ZHighin,
   output logic            Zlowin,
   output logic            HIin,
   output logic            LOin,
   output logic            Read,
   output logic            IncPC,
   output logic [OPW-1:0]  op,
   output logic [NREG-1:0] Rout,
   output logic [NREG-1:0] Rin,
   output logic            Done,
   output logic            Halted,
   output logic            Err,
   output logic [3:0]      State
);

   // State encoding, kept stable for debug tools that read State.
   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_T0   = 4'd1;
   localparam logic [3:0] S_T1   = 4'd2;
   localparam logic [3:0] S_T2   = 4'd3;
   localparam logic [3:0] S_T3   = 4'd4;
   localparam logic [3:0] S_T4   = 4'd5;
   localparam logic [3:0] S_T5   = 4'd6;
   localparam logic [3:0] S_T6   = 4'd7;
   localparam logic [3:0] S_HALT = 4'd8;
   localparam logic [3:0] S_ERR  = 4'd9;

   localparam logic [4:0] OPC_NEG  = 5'b00101;
   localparam logic [4:0] OPC_NOT  = 5'b00110;
   localparam logic [4:0] OPC_MUL  = 5'b01111;
   localparam logic [4:0] OPC_DIV  = 5'b10000;
   localparam logic [4:0] OPC_NOP  = 5'b11010;
   localparam logic [4:0] OPC_HALT = 5'b11011;

   logic [3:0] state;
   logic [3:0] state_next;

   // Instruction fields; IR is only meaningful from T3 onward.
   logic [4:0] opc;
   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] rc;
   logic       unused_ir;

   assign opc       = IR[31:27];
   assign ra        = IR[26:23];
   assign rb        = IR[22:19];
   assign rc        = IR[18:15];
   assign unused_ir = ^IR[14:0];

   // Opcode classes.
   logic is_bin;
   logic is_un;
   logic is_md;
   logic is_nop;
   logic is_halt;

   assign is_un   = (opc == OPC_NEG) || (opc == OPC_NOT);
   assign is_bin  = (opc <= 5'b00100) || ((opc >= 5'b00111) && (opc <= 5'b01110));
   assign is_md   = (opc == OPC_MUL) || (opc == OPC_DIV);
   assign is_nop  = (opc == OPC_NOP);
   assign is_halt = (opc == OPC_HALT);

   // One-hot register selects for the general-register buses.
   logic [NREG-1:0] sel_ra;
   logic [NREG-1:0] sel_rb;
   logic [NREG-1:0] sel_rc;
   logic [NREG-1:0] one;

   assign one    = {{(NREG-1){1'b0}}, 1'b1};
   assign sel_ra = one << ra;
   assign sel_rb = one << rb;
   assign sel_rc = one << rc;

   // Where to go after a completing T-state; Run is only looked at here and in IDLE.
   logic [3:0] after_done;
   assign after_done = Run ? S_T0 : S_IDLE;

   // State register; clear wins over everything else.
   always_ff @(posedge Clock) begin
      if (clear) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection by T-state and instruction class.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: state_next = Run ? S_T0 : S_IDLE;
         S_T0:   state_next = S_T1;
         S_T1:   state_next = S_T2;
         S_T2:   state_next = S_T3;
         S_T3: begin
            if (is_bin || is_un || is_md) begin
               state_next = S_T4;
            end else if (is_nop) begin
               state_next = after_done;
            end else if (is_halt) begin
               state_next = S_HALT;
            end else begin
               state_next = S_ERR;
            end
         end
         S_T4: begin
            if (is_un) begin
               state_next = after_done;
            end else if (is_bin || is_md) begin
               state_next = S_T5;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_T5: begin
            if (is_bin) begin
               state_next = after_done;
            end else if (is_md) begin
               state_next = S_T6;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_T6:   state_next = after_done;
         S_HALT: state_next = S_HALT;
         S_ERR:  state_next = S_ERR;
         default: state_next = S_IDLE;
      endcase
   end

   // Moore strobe decode from the registered state and IR fields.
   always_comb begin
      PCout    = 1'b0;
      MDRout   = 1'b0;
      Zhighout = 1'b0;
      Zlowout  = 1'b0;
      MARin    = 1'b0;
      PCin     = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      ZHighin  = 1'b0;
      Zlowin   = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      Read     = 1'b0;
      IncPC    = 1'b0;
      op       = '0;
      Rout     = '0;
      Rin      = '0;
      Done     = 1'b0;
      case (state)
         S_T0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            Zlowin = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            if (is_bin) begin
               Rout = sel_rb;
               Yin  = 1'b1;
            end else if (is_un) begin
               Rout    = sel_rb;
               op      = OPW'(opc);
               ZHighin = 1'b1;
               Zlowin  = 1'b1;
            end else if (is_md) begin
               Rout = sel_ra;
               Yin  = 1'b1;
            end else if (is_nop || is_halt) begin
               Done = 1'b1;
            end
         end
         S_T4: begin
            if (is_bin) begin
               Rout    = sel_rc;
               op      = OPW'(opc);
               ZHighin = 1'b1;
               Zlowin  = 1'b1;
            end else if (is_un) begin
               Zlowout = 1'b1;
               Rin     = sel_ra;
               Done    = 1'b1;
            end else if (is_md) begin
               Rout    = sel_rb;
               op      = OPW'(opc);
               ZHighin = 1'b1;
               Zlowin  = 1'b1;
            end
         end
         S_T5: begin
            if (is_bin) begin
               Zlowout = 1'b1;
               Rin     = sel_ra;
               Done    = 1'b1;
            end else if (is_md) begin
               Zlowout = 1'b1;
               LOin    = 1'b1;
            end
         end
         S_T6: begin
            if (is_md) begin
               Zhighout = 1'b1;
               HIin     = 1'b1;
               Done     = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // HALT and ERR are terminal until clear, so the flags follow the state directly.
   assign Halted = (state == S_HALT);
   assign Err    = (state == S_ERR);
   assign State  = state;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized self-checking bench for control_sequencer
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        clear = 1'b1;
   logic        Run = 1'b0;
   logic [31:0] IR = '0;
   logic        PCout, MDRout, Zhighout, Zlowout;
   logic        MARin, PCin, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin;
   logic        Read, IncPC;
   logic [4:0]  op;
   logic [15:0] Rout, Rin;
   logic        Done, Halted, Err;
   logic [3:0]  State;

   always #5 Clock = ~Clock;

   control_sequencer #(.NREG(16), .OPW(5)) dut (
      .Clock(Clock), .clear(clear), .Run(Run), .IR(IR),
      .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
      .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .ZHighin(ZHighin), .Zlowin(Zlowin), .HIin(HIin), .LOin(LOin),
      .Read(Read), .IncPC(IncPC), .op(op), .Rout(Rout), .Rin(Rin),
      .Done(Done), .Halted(Halted), .Err(Err), .State(State)
   );

   typedef struct packed {
      logic        pc_out, mdr_out, zh_out, zl_out;
      logic        mar_in, pc_in, mdr_in, ir_in, y_in, zh_in, zl_in, hi_in, lo_in;
      logic        rd, inc_pc;
      logic [4:0]  opv;
      logic [15:0] r_out, r_in;
      logic        done, halted, err;
   } obs_t;

   int   total = 0;
   int   bad = 0;
   obs_t exp_q[$];
   int   done_idx;
   int   tail_idx;
   obs_t zero_w = '0;

   function automatic obs_t sample();
      obs_t o;
      o.pc_out = PCout;  o.mdr_out = MDRout; o.zh_out = Zhighout; o.zl_out = Zlowout;
      o.mar_in = MARin;  o.pc_in = PCin;     o.mdr_in = MDRin;    o.ir_in = IRin;
      o.y_in = Yin;      o.zh_in = ZHighin;  o.zl_in = Zlowin;
      o.hi_in = HIin;    o.lo_in = LOin;     o.rd = Read;         o.inc_pc = IncPC;
      o.opv = op;        o.r_out = Rout;     o.r_in = Rin;
      o.done = Done;     o.halted = Halted;  o.err = Err;
      return o;
   endfunction

   task automatic step(input obs_t e, input string name);
      obs_t o;
      @(negedge Clock);
      o = sample();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, o, e);
      end
   endtask

   // Expected per-cycle outputs of one instruction, derived from the class rules.
   task automatic build_expected(input logic [31:0] ir);
      obs_t s;
      logic [4:0]  opc;
      logic [15:0] one_ra, one_rb, one_rc;
      opc    = ir[31:27];
      one_ra = 16'd1 << ir[26:23];
      one_rb = 16'd1 << ir[22:19];
      one_rc = 16'd1 << ir[18:15];
      exp_q.delete();
      done_idx = -1;
      tail_idx = 99;
      s = '0; s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; s.zl_in = 1; exp_q.push_back(s);
      s = '0; s.zl_out = 1; s.pc_in = 1; s.rd = 1; s.mdr_in = 1;     exp_q.push_back(s);
      s = '0; s.mdr_out = 1; s.ir_in = 1;                            exp_q.push_back(s);
      if (opc == 5 || opc == 6) begin
         s = '0; s.r_out = one_rb; s.opv = opc; s.zh_in = 1; s.zl_in = 1; exp_q.push_back(s);
         s = '0; s.zl_out = 1; s.r_in = one_ra; s.done = 1;              exp_q.push_back(s);
         done_idx = 4;
      end else if (opc <= 4 || (opc >= 7 && opc <= 14)) begin
         s = '0; s.r_out = one_rb; s.y_in = 1;                            exp_q.push_back(s);
         s = '0; s.r_out = one_rc; s.opv = opc; s.zh_in = 1; s.zl_in = 1; exp_q.push_back(s);
         s = '0; s.zl_out = 1; s.r_in = one_ra; s.done = 1;               exp_q.push_back(s);
         done_idx = 5;
      end else if (opc == 15 || opc == 16) begin
         s = '0; s.r_out = one_ra; s.y_in = 1;                            exp_q.push_back(s);
         s = '0; s.r_out = one_rb; s.opv = opc; s.zh_in = 1; s.zl_in = 1; exp_q.push_back(s);
         s = '0; s.zl_out = 1; s.lo_in = 1;                               exp_q.push_back(s);
         s = '0; s.zh_out = 1; s.hi_in = 1; s.done = 1;                   exp_q.push_back(s);
         done_idx = 6;
      end else if (opc == 26) begin
         s = '0; s.done = 1; exp_q.push_back(s);
         done_idx = 3;
      end else if (opc == 27) begin
         s = '0; s.done = 1; exp_q.push_back(s);
         done_idx = 3;
         tail_idx = 4;
         s = '0; s.halted = 1;
         repeat (3) exp_q.push_back(s);
      end else begin
         s = '0; exp_q.push_back(s);
         tail_idx = 4;
         s = '0; s.err = 1;
         repeat (3) exp_q.push_back(s);
      end
   endtask

   // Runs one instruction starting with T0 on the next sample; IR arrives after T2.
   task automatic exec_instr(input logic [31:0] ir, input logic run_after,
                             input int clear_after, input string name);
      build_expected(ir);
      for (int k = 0; k < exp_q.size(); k++) begin
         step(exp_q[k], $sformatf("%s t%0d", name, k));
         IR = (k >= 2) ? ir : $urandom;
         if (k == done_idx) Run = run_after;
         else if (k >= tail_idx - 1) Run = 1'b1;
         else Run = 1'($urandom);
         if (k == clear_after) begin
            clear = 1'b1;
            step(zero_w, {name, " after clear"});
            clear = 1'b0;
            Run   = 1'b0;
            break;
         end
      end
   endtask

   task automatic do_clear(input logic run_level);
      clear = 1'b1;
      Run   = 1'b1;
      step(zero_w, "clear to idle");
      clear = 1'b0;
      Run   = run_level;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc);
      return {opc, ra, rb, rc, 15'($urandom)};
   endfunction

   task automatic test_reset();
      clear = 1'b1;
      Run   = 1'b1;
      IR    = $urandom;
      step(zero_w, "reset c1");
      step(zero_w, "reset c2");
      clear = 1'b0;
      Run   = 1'b0;
      for (int i = 0; i < 5; i++) step(zero_w, $sformatf("idle %0d", i));
   endtask

   task automatic test_unary();
      Run = 1'b1;
      exec_instr(mk(5'b00101, 4'd1, 4'd2, 4'($urandom)), 1'b0, -1, "neg");
      step(zero_w, "neg then idle");
   endtask

   task automatic test_binary();
      Run = 1'b1;
      exec_instr(mk(5'b00011, 4'd3, 4'd4, 4'd5), 1'b1, -1, "bin");
      exec_instr(mk(5'b01001, 4'd2, 4'd2, 4'd9), 1'b0, -1, "bin chained");
      step(zero_w, "bin then idle");
   endtask

   task automatic test_muldiv();
      Run = 1'b1;
      exec_instr(mk(5'b01111, 4'd6, 4'd7, 4'($urandom)), 1'b0, -1, "mul");
      step(zero_w, "mul then idle");
   endtask

   task automatic test_halt_err();
      Run = 1'b1;
      exec_instr(mk(5'b11011, 4'($urandom), 4'($urandom), 4'($urandom)), 1'b1, -1, "halt");
      do_clear(1'b1);
      exec_instr(mk(5'b11111, 4'($urandom), 4'($urandom), 4'($urandom)), 1'b1, -1, "illegal");
      do_clear(1'b0);
      step(zero_w, "idle after err clear");
   endtask

   task automatic test_clear_mid();
      Run = 1'b1;
      exec_instr(mk(5'b00000, 4'd11, 4'd12, 4'd13), 1'b1, 4, "clear mid");
      step(zero_w, "idle after mid clear");
   endtask

   task automatic test_back_to_back();
      logic [4:0] opc;
      logic       ra_run;
      Run = 1'b1;
      for (int n = 0; n < 60; n++) begin
         opc    = 5'($urandom);
         ra_run = 1'($urandom);
         exec_instr(mk(opc, 4'($urandom), 4'($urandom), 4'($urandom)), ra_run, -1,
                    $sformatf("rnd%0d op%0d", n, opc));
         if (opc == 27 || !(opc <= 16 || opc == 26)) begin
            do_clear(1'b1);
         end else if (!ra_run) begin
            step(zero_w, $sformatf("rnd%0d idle", n));
            Run = 1'b1;
         end
      end
      do_clear(1'b0);
   endtask

   initial begin
      test_reset();
      test_unary();
      test_binary();
      test_muldiv();
      test_halt_err();
      test_clear_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired multi-cycle control unit that drives the control inputs of data_path.
- Replaces hand-sequenced testbench stimulus: fetches an instruction, decodes IR, and steps T-states for ALU register operations (binary, unary, MUL/DIV), HALT and NOP.
- Sits directly upstream of data_path. IR comes back from the datapath; every register-transfer strobe and the ALU op code come out of this block.

Parameters:
- NREG, 16, number of general registers; width of the one-hot Rout/Rin buses.
- OPW, 5, opcode and ALU op width.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  synchronous active-high reset.
- Run  in  1  level; high allows a fetch to start from IDLE and chains instructions.
- IR  in  32  instruction register from data_path, valid from T3 onward.
- PCout, MDRout, Zhighout, Zlowout  out  1 each  bus drive strobes.
- MARin, PCin, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin  out  1 each  register load strobes.
- Read  out  1  memory read into MDR.
- IncPC  out  1  ALU computes PC+1 into Z.
- op  out  5  ALU operation code.
- Rout  out  16  one-hot general-register bus drive.
- Rin  out  16  one-hot general-register load.
- Done  out  1  one-cycle pulse on the last T-state of a completed instruction.
- Halted  out  1  sticky; set by HALT.
- Err  out  1  sticky; set by an illegal opcode.
- State  out  4  current state encoding, for debug.

Behaviour:
- Instruction fields: opc=IR[31:27], Ra=IR[26:23] (destination), Rb=IR[22:19], Rc=IR[18:15].
- Opcode classes:
  - Binary: 00000–00100 and 00111–01110. Ra <= Rb op Rc.
  - Unary: 00101 NEG, 00110 NOT. Ra <= op Rb.
  - MULDIV: 01111 MUL, 10000 DIV. Operands Ra, Rb; HI<=Z high, LO<=Z low.
  - NOP: 11010. HALT: 11011. Every other opcode is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, ERR.
- Outputs are Moore-decoded from the registered state plus the IR fields. Every strobe not listed for a state is 0. op=0 except where listed.
- IDLE: all strobes 0. Go to T0 when Run=1, else stay.
- T0: PCout, MARin, IncPC, Zlowin. Go to T1.
- T1: Zlowout, PCin, Read, MDRin. Go to T2.
- T2: MDRout, IRin. Go to T3.
- T3 by class:
  - Binary: Rout[Rb], Yin.
  - Unary: Rout[Rb], op=opc, ZHighin, Zlowin.
  - MULDIV: Rout[Ra], Yin.
  - NOP: Done.
  - HALT: Done; next state HALT.
  - Illegal: next state ERR, no Done.
- T4 by class:
  - Binary: Rout[Rc], op=opc, ZHighin, Zlowin.
  - Unary: Zlowout, Rin[Ra], Done.
  - MULDIV: Rout[Rb], op=opc, ZHighin, Zlowin.
- T5 by class:
  - Binary: Zlowout, Rin[Ra], Done.
  - MULDIV: Zlowout, LOin.
- T6 (MULDIV only): Zhighout, HIin, Done.
- After a Done state: go to T0 if Run=1, else IDLE. Run is sampled only in IDLE and on Done cycles; deasserting it mid-instruction does not abort.
- HALT state: Halted=1, all strobes 0. Exit only via clear.
- ERR state: Err=1, all strobes 0. Exit only via clear.
- Latency from T0 to Done: NOP/HALT 4 cycles, unary 5, binary 6, MULDIV 7.
- Reset (clear=1 at a rising edge), from any state including mid-instruction:
  - State=IDLE, Halted=0, Err=0, Done=0.
  - All strobes 0, op=0, Rout=Rin=0.
  - clear has priority over Run.
- Invariants:
  - At most one of PCout, MDRout, Zhighout, Zlowout, Rout[*] is high in any cycle.
  - Rout and Rin are each one-hot or zero.
  - Ra=Rb is legal (e.g. NEG R2,R2).

Test Plan:
- clear=1 for 2 cycles, then Run=0 for 5 cycles -> State=IDLE; all outputs 0; Done never pulses.
- Run=1; IR loaded in T2 with opc=00101, Ra=1, Rb=2 -> T0–T2 fetch strobes as specified; T3: Rout=16'h0004, op=00101, ZHighin=Zlowin=1; T4: Zlowout=1, Rin=16'h0002, Done=1; Done occurs 5 cycles after T0.
- IR opc=00011, Ra=3, Rb=4, Rc=5 -> T3: Rout=16'h0010, Yin=1; T4: Rout=16'h0020, op=00011; T5: Rin=16'h0008, Done=1; with Run held high the next cycle is T0.
- IR opc=01111, Ra=6, Rb=7 -> T5: Zlowout=1, LOin=1; T6: Zhighout=1, HIin=1, Done=1; no Rin bit asserted anywhere in the instruction.
- IR opc=11011, then IR opc=11111 after a clear -> first: Done in T3, then Halted=1 held with all strobes 0 while Run=1; second: Err=1 with no Done; clear returns to IDLE with both flags 0.
- clear asserted during T4 of a binary instruction -> next cycle IDLE; Rin stays 0, so the destination register is never written.
